// File: rtl/ds_inst_queue_pkg.sv
// Shared constants for the decode-stage instruction queue: default widths,
// the kill NOP, exception codes and {inst, pc} bus field offsets.
package ds_inst_queue_pkg;

    localparam int EXC_W = 6;

    // ADD x0,x0,x0: a harmless instruction for killed wrong-path slots
    localparam logic [31:0] NOP_INST = 32'h0000_0033;

    localparam logic [EXC_W-1:0] EXC_ILLEGAL = 6'b100010;
    localparam logic [EXC_W-1:0] EXC_EBREAK  = 6'b100011;
    localparam logic [EXC_W-1:0] EXC_ECALL   = 6'b101011;
    localparam logic [EXC_W-1:0] EXC_MRET    = 6'b011111;

    // Bus layout is {inst, pc}: pc in the low bits, inst directly above it
    localparam int BUS_PC_LSB = 0;

    function automatic int bus_inst_lsb(input int pc_w);
        return pc_w;
    endfunction

endpackage

// File: rtl/ds_inst_queue_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for the
// instruction queue; slave is the queue, master is its surroundings.
interface ds_inst_queue_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = ds_inst_queue_pkg::EXC_W
);
    logic                     fs_to_ds_valid;
    logic                     ds_allowin;
    logic [INST_W+PC_W-1:0]   fs_bus_in;
    logic [EXC_W-1:0]         fs_exc_code;
    logic                     ds_ready_go;
    logic                     es_allowin;
    logic                     ds_to_es_valid;
    logic [INST_W+PC_W-1:0]   ds_bus_out;
    logic [EXC_W-1:0]         ds_exc_code;

    modport slave (
        input  fs_to_ds_valid, fs_bus_in, fs_exc_code, ds_ready_go, es_allowin,
        output ds_allowin, ds_to_es_valid, ds_bus_out, ds_exc_code
    );

    modport master (
        output fs_to_ds_valid, fs_bus_in, fs_exc_code, ds_ready_go, es_allowin,
        input  ds_allowin, ds_to_es_valid, ds_bus_out, ds_exc_code
    );
endinterface

// File: rtl/ds_inst_queue_mem.sv
// Queue storage: DEPTH x WIDTH register array, one synchronous write port
// and one asynchronous read port. Contents are not reset.
module ds_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 70
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    import ds_inst_queue_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ds_inst_queue.sv
// In-order DEPTH-entry queue between fetch and decode carrying {inst, pc}
// plus an exception code, with branch kill of younger entries and flush.
module ds_inst_queue #(
    parameter int                DEPTH    = 4,
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter int                EXC_W    = ds_inst_queue_pkg::EXC_W,
    parameter logic [INST_W-1:0] NOP_INST = ds_inst_queue_pkg::NOP_INST
) (
    input  logic                         clk,
    input  logic                         rst_n,
    ds_inst_queue_if.slave               q,
    input  logic                         br_kill,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    import ds_inst_queue_pkg::*;

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH+1);
    localparam int BUS_W    = INST_W + PC_W;
    localparam int ENT_W    = BUS_W + EXC_W;
    localparam int INST_LSB = bus_inst_lsb(PC_W);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;
    logic [BUS_W-1:0] head_bus;
    logic [EXC_W-1:0] head_exc;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Backpressure depends on occupancy only, so a full queue never
    // accepts even when the head is leaving this cycle.
    assign q.ds_allowin     = !full;
    assign push             = q.fs_to_ds_valid && q.ds_allowin && !flush && !br_kill;
    assign q.ds_to_es_valid = !empty && q.ds_ready_go && !flush;
    assign pop              = q.ds_to_es_valid && q.es_allowin;

    ds_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({q.fs_exc_code, q.fs_bus_in}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign head_bus = head[BUS_W-1:0];
    assign head_exc = head[ENT_W-1 -: EXC_W];

    // A killed head still issues with its pc, but as a NOP; a genuine
    // exception (MSB set) survives the kill so it can still be taken.
    always_comb begin
        q.ds_bus_out  = '0;
        q.ds_exc_code = '0;
        if (!empty) begin
            q.ds_bus_out  = head_bus;
            q.ds_exc_code = head_exc;
            if (br_kill) begin
                q.ds_bus_out[INST_LSB +: INST_W] = NOP_INST;
                if (!head_exc[EXC_W-1]) begin
                    q.ds_exc_code = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (br_kill && !empty) begin
            // Keep only the head; it leaves too if issued this cycle
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= rd_ptr + PTR_W'(1);
            count  <= {{(CNT_W-1){1'b0}}, !pop};
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ds_inst_queue.sv
// Directed bench for ds_inst_queue: table of per-cycle vectors plus
// hand-written pointer-wrap and asynchronous-reset sequences.
module tb_ds_inst_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0033;

    logic       clk;
    logic       rst_n;
    logic       br_kill;
    logic       flush;
    logic [2:0] count;

    ds_inst_queue_if #(.PC_W(32), .INST_W(32), .EXC_W(6)) bus_if ();

    ds_inst_queue #(
        .DEPTH(DEPTH), .PC_W(32), .INST_W(32), .EXC_W(6), .NOP_INST(NOP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .q       (bus_if.slave),
        .br_kill (br_kill),
        .flush   (flush),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [5:0]  exc;
        logic        rg;
        logic        ea;
        logic        bk;
        logic        fl;
        logic        e_allow;
        logic        e_tov;
        logic [63:0] e_bus;
        logic [5:0]  e_exc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    function automatic logic [63:0] hb(input logic [31:0] pc);
        return {inst_of(pc), pc};
    endfunction

    function automatic logic [63:0] nb(input logic [31:0] pc);
        return {NOP, pc};
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [5:0] exc,
                                input logic rg, input logic ea, input logic bk, input logic fl,
                                input logic e_allow, input logic e_tov, input logic [63:0] e_bus,
                                input logic [5:0] e_exc, input logic [2:0] e_cnt);
        vec_t r;
        r.v = v; r.pc = pc; r.exc = exc; r.rg = rg; r.ea = ea; r.bk = bk; r.fl = fl;
        r.e_allow = e_allow; r.e_tov = e_tov; r.e_bus = e_bus; r.e_exc = e_exc; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [5:0] exc,
                         input logic rg, input logic ea, input logic bk, input logic fl);
        @(negedge clk);
        bus_if.fs_to_ds_valid = v;
        bus_if.fs_bus_in      = {inst_of(pc), pc};
        bus_if.fs_exc_code    = exc;
        bus_if.ds_ready_go    = rg;
        bus_if.es_allowin     = ea;
        br_kill               = bk;
        flush                 = fl;
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_allow, input logic e_tov,
                           input logic [63:0] e_bus, input logic [5:0] e_exc, input logic [2:0] e_cnt);
        chk({tag, ".allowin"}, 64'(bus_if.ds_allowin), 64'(e_allow));
        chk({tag, ".to_es_valid"}, 64'(bus_if.ds_to_es_valid), 64'(e_tov));
        chk({tag, ".bus_out"}, bus_if.ds_bus_out, e_bus);
        chk({tag, ".exc_code"}, 64'(bus_if.ds_exc_code), 64'(e_exc));
        chk({tag, ".count"}, 64'(count), 64'(e_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // fill to full, fifth offer (with a pop) refused, drain in order
        tbl.push_back(mk(1, 32'h00, 0, 1, 0, 0, 0,  1, 0, 64'h0,   0, 0));
        tbl.push_back(mk(1, 32'h04, 0, 1, 0, 0, 0,  1, 1, hb(32'h00), 0, 1));
        tbl.push_back(mk(1, 32'h08, 0, 1, 0, 0, 0,  1, 1, hb(32'h00), 0, 2));
        tbl.push_back(mk(1, 32'h0C, 0, 1, 0, 0, 0,  1, 1, hb(32'h00), 0, 3));
        tbl.push_back(mk(1, 32'h10, 0, 1, 0, 0, 0,  0, 1, hb(32'h00), 0, 4));
        tbl.push_back(mk(1, 32'h10, 0, 1, 1, 0, 0,  0, 1, hb(32'h00), 0, 4));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 0, 0,  1, 1, hb(32'h04), 0, 3));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 0, 0,  1, 1, hb(32'h08), 0, 2));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 0, 0,  1, 1, hb(32'h0C), 0, 1));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 0, 0,  1, 0, 64'h0,   0, 0));
        // br_kill with the head popped: all entries gone, push dropped
        tbl.push_back(mk(1, 32'h10, 0, 1, 0, 0, 0,  1, 0, 64'h0,   0, 0));
        tbl.push_back(mk(1, 32'h14, 0, 1, 0, 0, 0,  1, 1, hb(32'h10), 0, 1));
        tbl.push_back(mk(1, 32'h18, 0, 1, 0, 0, 0,  1, 1, hb(32'h10), 0, 2));
        tbl.push_back(mk(1, 32'h1C, 0, 1, 1, 1, 0,  1, 1, nb(32'h10), 0, 3));
        tbl.push_back(mk(0, 32'h00, 0, 1, 0, 0, 0,  1, 0, 64'h0,   0, 0));
        // br_kill with the head held: only the head survives
        tbl.push_back(mk(1, 32'h10, 0, 1, 0, 0, 0,  1, 0, 64'h0,   0, 0));
        tbl.push_back(mk(1, 32'h14, 0, 1, 0, 0, 0,  1, 1, hb(32'h10), 0, 1));
        tbl.push_back(mk(1, 32'h18, 0, 1, 0, 0, 0,  1, 1, hb(32'h10), 0, 2));
        tbl.push_back(mk(1, 32'h1C, 0, 1, 0, 1, 0,  1, 1, nb(32'h10), 0, 3));
        tbl.push_back(mk(0, 32'h00, 0, 1, 0, 0, 0,  1, 1, hb(32'h10), 0, 1));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 0, 0,  1, 1, hb(32'h10), 0, 1));
        // flush with a push offered
        tbl.push_back(mk(1, 32'h20, 0, 1, 0, 0, 0,  1, 0, 64'h0,   0, 0));
        tbl.push_back(mk(1, 32'h24, 0, 1, 0, 0, 0,  1, 1, hb(32'h20), 0, 1));
        tbl.push_back(mk(1, 32'h28, 0, 1, 1, 0, 1,  1, 0, hb(32'h20), 0, 2));
        tbl.push_back(mk(0, 32'h00, 0, 1, 0, 0, 0,  1, 0, 64'h0,   0, 0));
        // exception code with MSB set survives br_kill
        tbl.push_back(mk(1, 32'h30, 6'b100001, 1, 0, 0, 0,  1, 0, 64'h0, 0, 0));
        tbl.push_back(mk(1, 32'h34, 6'b100010, 1, 0, 0, 0,  1, 1, hb(32'h30), 6'b100001, 1));
        tbl.push_back(mk(0, 32'h00, 0, 1, 0, 1, 0,  1, 1, nb(32'h30), 6'b100001, 2));
        tbl.push_back(mk(0, 32'h00, 0, 1, 0, 0, 0,  1, 1, hb(32'h30), 6'b100001, 1));
        tbl.push_back(mk(0, 32'h00, 0, 1, 0, 0, 1,  1, 0, hb(32'h30), 6'b100001, 1));
        // code with MSB clear is zeroed under br_kill
        tbl.push_back(mk(1, 32'h40, 6'b011111, 1, 0, 0, 0,  1, 0, 64'h0, 0, 0));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 1, 0,  1, 1, nb(32'h40), 0, 1));
        tbl.push_back(mk(0, 32'h00, 0, 1, 0, 0, 0,  1, 0, 64'h0,   0, 0));
        // decode stall holds the head while pushes continue
        tbl.push_back(mk(1, 32'h50, 0, 0, 1, 0, 0,  1, 0, 64'h0,   0, 0));
        tbl.push_back(mk(1, 32'h54, 0, 0, 1, 0, 0,  1, 0, hb(32'h50), 0, 1));
        tbl.push_back(mk(0, 32'h00, 0, 0, 1, 0, 0,  1, 0, hb(32'h50), 0, 2));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 0, 0,  1, 1, hb(32'h50), 0, 2));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 0, 0,  1, 1, hb(32'h54), 0, 1));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 0, 0,  1, 0, 64'h0,   0, 0));
        // simultaneous push and pop keeps count
        tbl.push_back(mk(1, 32'h60, 0, 1, 1, 0, 0,  1, 0, 64'h0,   0, 0));
        tbl.push_back(mk(1, 32'h64, 0, 1, 1, 0, 0,  1, 1, hb(32'h60), 0, 1));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 0, 0,  1, 1, hb(32'h64), 0, 1));
        tbl.push_back(mk(0, 32'h00, 0, 1, 1, 0, 0,  1, 0, 64'h0,   0, 0));

        rst_n                 = 1'b0;
        bus_if.fs_to_ds_valid = 1'b0;
        bus_if.fs_bus_in      = '0;
        bus_if.fs_exc_code    = '0;
        bus_if.ds_ready_go    = 1'b0;
        bus_if.es_allowin     = 1'b0;
        br_kill               = 1'b0;
        flush                 = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 1, 0, 64'h0, 0, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].exc, tbl[i].rg, tbl[i].ea, tbl[i].bk, tbl[i].fl);
            chk_all($sformatf("vec%0d", i), tbl[i].e_allow, tbl[i].e_tov,
                    tbl[i].e_bus, tbl[i].e_exc, tbl[i].e_cnt);
        end

        // pointer wrap: 3*DEPTH push/pop pairs, head trails push by one
        for (int i = 0; i < 3*DEPTH; i++) begin
            drive(1, 32'h100 + 32'(4*i), 0, 1, 1, 0, 0);
            if (i > 0) begin
                chk_all($sformatf("wrap%0d", i), 1, 1, hb(32'h100 + 32'(4*(i-1))), 0, 1);
            end
        end
        drive(0, 0, 0, 1, 1, 0, 0);
        chk_all("wrap_last", 1, 1, hb(32'h100 + 32'(4*(3*DEPTH-1))), 0, 1);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk_all("wrap_empty", 1, 0, 64'h0, 0, 0);

        // asynchronous reset mid-stream
        drive(1, 32'h200, 0, 1, 0, 0, 0);
        drive(1, 32'h204, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("pre_rst.count", 64'(count), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1, 0, 64'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0, 0, 0);
        chk_all("post_rst", 1, 0, 64'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
